// File: rtl/cpu_bus_arb.sv
// cpu_bus_arb: sprite-DMA bus arbiter for the CPU-clock system bus. It halts the 6502 through RDY,
// hands the bus to the DMA master and parks it around the handover. Macro CPU_BUS_ARB_ALIGN_EN adds the ALIGN state.
module cpu_bus_arb #(
   parameter logic [15:0] PARK_ADDR = 16'h0000
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic [15:0] i_cpu_addr,
   input  logic        i_cpu_wn,
   input  logic [7:0]  i_cpu_wdata,
   output logic        o_cpu_rdy,
   output logic [7:0]  o_cpu_rdata,
   input  logic        i_spr_req,
   output logic        o_spr_gnt,
   input  logic [15:0] i_spr_addr,
   input  logic        i_spr_wn,
   input  logic [7:0]  i_spr_wdata,
   output logic [7:0]  o_spr_rdata,
   output logic [15:0] o_bus_addr,
   output logic        o_bus_wn,
   output logic [7:0]  o_bus_wdata,
   input  logic [7:0]  i_bus_rdata,
   output logic [9:0]  o_stall_cnt
);

   localparam logic [9:0] STALL_MAX = 10'h3FF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
`ifdef CPU_BUS_ARB_ALIGN_EN
      ST_ALIGN   = 3'd2,
`endif
      ST_GRANT   = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic        rdy_r;
   logic        gnt_r;
   logic [9:0]  stall_cnt_r;
   logic [9:0]  stall_out_r;
   logic [9:0]  stall_inc_s;
   logic        dma_start_s;
   logic        dma_done_s;
   logic [15:0] bus_addr_s;
   logic        bus_wn_s;
   logic [7:0]  bus_wdata_s;
`ifdef CPU_BUS_ARB_ALIGN_EN
   logic        parity_r;
`endif

   function automatic logic [9:0] sat_inc(input logic [9:0] value);
      logic [9:0] result;
      if (value == STALL_MAX) begin
         result = value;
      end else begin
         result = value + 10'd1;
      end
      return result;
   endfunction

`ifdef CPU_BUS_ARB_ALIGN_EN
   function automatic logic parity_next(input logic parity);
      return ~parity;
   endfunction
`endif

   // Next-state logic; an abort (request dropped before grant) wins over everything else.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (i_spr_req) begin
               state_s = ST_WAIT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!i_spr_req) begin
               state_s = ST_RELEASE;
            end else if (!i_cpu_wn) begin
               // The 6502 ignores RDY during writes, so it is not halted yet.
               state_s = ST_WAIT;
            end else begin
`ifdef CPU_BUS_ARB_ALIGN_EN
               if (parity_r) begin
                  state_s = ST_ALIGN;
               end else begin
                  state_s = ST_GRANT;
               end
`else
               state_s = ST_GRANT;
`endif
            end
         end
`ifdef CPU_BUS_ARB_ALIGN_EN
         ST_ALIGN: begin
            if (!i_spr_req) begin
               state_s = ST_RELEASE;
            end else begin
               state_s = ST_GRANT;
            end
         end
`endif
         ST_GRANT: begin
            if (i_spr_req) begin
               state_s = ST_GRANT;
            end else begin
               state_s = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Session boundary strobes and the saturated stall increment.
   always_comb begin
      dma_start_s = (state_r == ST_IDLE) && (state_s == ST_WAIT);
      dma_done_s  = (state_r == ST_RELEASE) && (state_s == ST_IDLE);
      stall_inc_s = sat_inc(stall_cnt_r);
   end

   // Bus owner mux; a halted CPU read must never reach the bus (side-effect registers).
   always_comb begin
      bus_addr_s  = PARK_ADDR;
      bus_wn_s    = 1'b1;
      bus_wdata_s = 8'h00;
      case (state_r)
         ST_IDLE: begin
            bus_addr_s  = i_cpu_addr;
            bus_wn_s    = i_cpu_wn;
            bus_wdata_s = i_cpu_wdata;
         end
         ST_WAIT: begin
            if (!i_cpu_wn) begin
               bus_addr_s  = i_cpu_addr;
               bus_wn_s    = 1'b0;
               bus_wdata_s = i_cpu_wdata;
            end else begin
               bus_addr_s  = PARK_ADDR;
               bus_wn_s    = 1'b1;
               bus_wdata_s = 8'h00;
            end
         end
         ST_GRANT: begin
            bus_addr_s  = i_spr_addr;
            bus_wn_s    = i_spr_wn;
            bus_wdata_s = i_spr_wdata;
         end
         default: begin
            bus_addr_s  = PARK_ADDR;
            bus_wn_s    = 1'b1;
            bus_wdata_s = 8'h00;
         end
      endcase
   end

   // State register with registered RDY and grant derived from the next state.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_r <= ST_IDLE;
         rdy_r   <= 1'b1;
         gnt_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         rdy_r   <= (state_s == ST_IDLE);
         gnt_r   <= (state_s == ST_GRANT);
      end
   end

   // Stall counter; the published value includes the final RELEASE cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         stall_cnt_r <= 10'd0;
         stall_out_r <= 10'd0;
      end else begin
         if (dma_start_s) begin
            stall_cnt_r <= 10'd0;
         end else if (!rdy_r) begin
            stall_cnt_r <= stall_inc_s;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (dma_done_s) begin
            stall_out_r <= stall_inc_s;
         end else begin
            stall_out_r <= stall_out_r;
         end
      end
   end

`ifdef CPU_BUS_ARB_ALIGN_EN
   // Get/put cycle parity; grants are only issued from an even cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         parity_r <= 1'b0;
      end else begin
         parity_r <= parity_next(parity_r);
      end
   end
`endif

   assign o_cpu_rdy   = rdy_r;
   assign o_spr_gnt   = gnt_r;
   assign o_stall_cnt = stall_out_r;
   assign o_bus_addr  = bus_addr_s;
   assign o_bus_wn    = bus_wn_s;
   assign o_bus_wdata = bus_wdata_s;
   assign o_cpu_rdata = i_bus_rdata;
   assign o_spr_rdata = i_bus_rdata;

endmodule
